causal_history_reader: RTL and testbench

CAUSAL_HISTORY_READER -- requirements
Module: causal_history_reader

---
 rtl/causal_history_reader_pkg.sv | 47 ++++
 rtl/causal_history_reader_entry_serializer.sv | 50 +++++
 rtl/causal_history_reader.sv | 212 +++++++++++++++++++++
 tb/tb_causal_history_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/causal_history_reader_pkg.sv
// Shared definitions for the history dump reader: FSM states, framing bytes
// and the bit layout of one 32-bit history entry.  The lattice FSM writer
// builds entries with the same offsets so both ends agree on the layout.
package causal_history_reader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SYNC,
        ST_DATA,
        ST_TR_MARK,
        ST_TR_CNT,
        ST_TR_FLAG,
        ST_FIN
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] TRAIL_BYTE = 8'h5A;

    localparam int ENTRY_W  = 32;
    localparam int TS_LSB   = 16;
    localparam int TS_W     = 16;
    localparam int TRIG_LSB = 13;
    localparam int TRIG_W   = 3;
    localparam int FROM_LSB = 8;
    localparam int FROM_W   = 5;
    localparam int TO_LSB   = 3;
    localparam int TO_W     = 5;

    // Assemble one history entry from its fields; the low pad bits stay zero.
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [TS_W-1:0]   ts,
        input logic [TRIG_W-1:0] trig,
        input logic [FROM_W-1:0] from_state,
        input logic [TO_W-1:0]   to_state
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[TS_LSB   +: TS_W]   = ts;
        e[TRIG_LSB +: TRIG_W] = trig;
        e[FROM_LSB +: FROM_W] = from_state;
        e[TO_LSB   +: TO_W]   = to_state;
        return e;
    endfunction

endpackage

// File: rtl/causal_history_reader_entry_serializer.sv
// causal_entry_serializer: holds one latched 32-bit entry and hands it out
// as four bytes, most-significant first, over a valid/ready handshake.
module causal_entry_serializer
    import causal_history_reader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [ENTRY_W-1:0] load_data_i,
    input  logic               go_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [7:0]         data_o,
    output logic               last_o
);

    logic [ENTRY_W-1:0] shift_q;
    logic [1:0]         cnt_q;
    logic               valid_q;
    logic               accept;

    assign accept  = valid_q && ready_i;
    assign last_o  = accept && (cnt_q == 2'd3);
    assign valid_o = valid_q;
    assign data_o  = shift_q[ENTRY_W-1 -: 8];

    // Load captures a fresh entry; go starts presenting it; each accepted
    // byte shifts the next one up, and the fourth acceptance ends the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= load_data_i;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else if (go_i) begin
            valid_q <= 1'b1;
        end else if (accept) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                valid_q <= 1'b0;
            end else begin
                shift_q <= {shift_q[ENTRY_W-9:0], 8'h00};
            end
        end
    end

endmodule

// File: rtl/causal_history_reader.sv
// causal_history_reader: dumps the history RAM as a framed byte stream.
// Each entry goes out as A5 followed by its four bytes; the frame ends with
// 5A, the entry count and an overflow flag.  Writer activity during a dump
// is tracked so that overwritten-but-unread entries are reported.
module causal_history_reader
    import causal_history_reader_pkg::*;
#(
    parameter int HISTORY_DEPTH = 128,
    parameter int PTR_BITS      = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PTR_BITS-1:0] wr_ptr,
    input  logic                wr_wrapped,
    input  logic                wr_strobe,
    output logic                rd_en,
    output logic [PTR_BITS-1:0] rd_addr,
    input  logic [31:0]         rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    // Counts reach HISTORY_DEPTH, so they need one bit more than a pointer;
    // the overflow threshold can reach twice that.
    localparam int CNT_W = PTR_BITS + 1;
    localparam int THR_W = PTR_BITS + 2;

    state_t              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [PTR_BITS-1:0] base_q;
    logic [CNT_W-1:0]    idx_q;
    logic [CNT_W-1:0]    latched_q;
    logic [7:0]          wr_cnt_q;
    logic                overflow_q;
    logic                rd_en_q;
    logic [PTR_BITS-1:0] rd_addr_q;
    logic                hdr_valid_q;
    logic [7:0]          hdr_data_q;
    logic                busy_q;
    logic                done_q;

    logic [CNT_W-1:0]    snap_count;
    logic [PTR_BITS-1:0] snap_base;
    logic [CNT_W-1:0]    idx_next;
    logic [THR_W-1:0]    threshold;
    logic                ovf_hit;
    logic                ser_load;
    logic                ser_go;
    logic                ser_valid;
    logic [7:0]          ser_data;
    logic                ser_last;

    // A wrapped writer means the whole RAM is valid and the oldest entry
    // sits at the next-write slot; otherwise entries 0..wr_ptr-1 are valid.
    assign snap_count = wr_wrapped ? CNT_W'(HISTORY_DEPTH) : {1'b0, wr_ptr};
    assign snap_base  = wr_wrapped ? wr_ptr : '0;
    assign idx_next   = idx_q + CNT_W'(1);

    // The writer may safely advance into the free slots plus the slots
    // whose entries have already been latched; beyond that it clobbered
    // something still waiting to be read.
    assign threshold = THR_W'(HISTORY_DEPTH) - THR_W'(count_q) + THR_W'(latched_q);
    assign ovf_hit   = busy_q && (32'(wr_cnt_q) > 32'(threshold));

    assign ser_load = (state_q == ST_LATCH);
    assign ser_go   = (state_q == ST_SYNC) && tx_ready;

    causal_entry_serializer u_serializer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (ser_load),
        .load_data_i (rd_data),
        .go_i        (ser_go),
        .ready_i     (tx_ready),
        .valid_o     (ser_valid),
        .data_o      (ser_data),
        .last_o      (ser_last)
    );

    assign tx_valid = (state_q == ST_DATA) ? ser_valid : hdr_valid_q;
    assign tx_data  = (state_q == ST_DATA) ? ser_data  : hdr_data_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

    // Writer activity: count strobes while a dump runs and latch overflow;
    // a strobe coinciding with the accepted start happens before the
    // snapshot and is deliberately not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= 8'd0;
            overflow_q <= 1'b0;
        end else if (!busy_q) begin
            if (start) begin
                wr_cnt_q   <= 8'd0;
                overflow_q <= 1'b0;
            end
        end else begin
            if (wr_strobe && (wr_cnt_q != 8'hFF)) begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
            if (ovf_hit) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Dump sequencer: window snapshot, RAM fetch per entry, SYNC framing,
    // trailer, and the done pulse; header/trailer bytes are registered here
    // and held until the consumer accepts them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            latched_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        count_q   <= snap_count;
                        base_q    <= snap_base;
                        idx_q     <= '0;
                        latched_q <= '0;
                        busy_q    <= 1'b1;
                        if (snap_count != '0) begin
                            state_q   <= ST_FETCH;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= snap_base;
                        end else begin
                            state_q     <= ST_TR_MARK;
                            hdr_valid_q <= 1'b1;
                            hdr_data_q  <= TRAIL_BYTE;
                        end
                    end
                end
                ST_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    latched_q   <= latched_q + CNT_W'(1);
                    hdr_valid_q <= 1'b1;
                    hdr_data_q  <= SYNC_BYTE;
                    state_q     <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (tx_ready) begin
                        hdr_valid_q <= 1'b0;
                        state_q     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ser_last) begin
                        idx_q <= idx_next;
                        if (idx_next < count_q) begin
                            state_q   <= ST_FETCH;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= base_q + idx_next[PTR_BITS-1:0];
                        end else begin
                            state_q     <= ST_TR_MARK;
                            hdr_valid_q <= 1'b1;
                            hdr_data_q  <= TRAIL_BYTE;
                        end
                    end
                end
                ST_TR_MARK: begin
                    if (tx_ready) begin
                        hdr_data_q <= 8'(count_q);
                        state_q    <= ST_TR_CNT;
                    end
                end
                ST_TR_CNT: begin
                    if (tx_ready) begin
                        hdr_data_q <= {7'b0, overflow_q | ovf_hit};
                        state_q    <= ST_TR_FLAG;
                    end
                end
                ST_TR_FLAG: begin
                    if (tx_ready) begin
                        hdr_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_causal_history_reader.sv
// Bench for causal_history_reader: a RAM model answers reads, a monitor
// collects accepted bytes and read addresses, and a frame model built from
// the dump rules supplies the expected stream for each scenario.
module tb_causal_history_reader;
   import causal_history_reader_pkg::*;

   localparam int DEPTH  = 128;
   localparam int PB     = 7;
   localparam int BUDGET = 20000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [PB-1:0] wr_ptr;
   logic          wr_wrapped;
   logic          wr_strobe;
   logic          rd_en;
   logic [PB-1:0] rd_addr;
   logic [31:0]   rd_data;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic          done;
   logic          overflow;

   int errors = 0;
   int checks = 0;

   logic [31:0] ram [DEPTH];
   logic [7:0]  gotBytes [$];
   logic [7:0]  expBytes [$];
   int          gotAddr [$];
   int          expAddr [$];
   int          doneCnt;
   int          stableErr;
   bit          prevStall;
   logic [7:0]  prevData;
   int          readyMode;

   typedef struct {
      string name;
      bit    wrapped;
      int    ptr;
      int    rmode;
      int    stall;
      int    strobes;
      bit    strobeWithStart;
      int    restartAt;
      int    expFlag;
   } vec_t;

   vec_t vecs [$];

   always #5 clk = ~clk;

   causal_history_reader #(.HISTORY_DEPTH(DEPTH), .PTR_BITS(PB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .wr_ptr     (wr_ptr),
      .wr_wrapped (wr_wrapped),
      .wr_strobe  (wr_strobe),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   // Synchronous-read RAM: data appears the cycle after the read enable.
   always @(posedge clk) begin
      if (rd_en) rd_data <= ram[rd_addr];
   end

   // Monitor sampled mid-cycle: records accepted bytes, read addresses and
   // done pulses, and flags any change of a stalled byte.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall && (tx_valid !== 1'b1 || tx_data !== prevData)) stableErr++;
         prevStall = tx_valid && !tx_ready;
         prevData  = tx_data;
         if (tx_valid && tx_ready) gotBytes.push_back(tx_data);
         if (rd_en) gotAddr.push_back(int'(rd_addr));
         if (done) doneCnt++;
      end
   end

   function automatic vec_t mk(string n, bit w, int p, int rm, int st, int sb,
                               bit sws, int ra, int ef);
      vec_t v;
      v.name = n; v.wrapped = w; v.ptr = p; v.rmode = rm; v.stall = st;
      v.strobes = sb; v.strobeWithStart = sws; v.restartAt = ra; v.expFlag = ef;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic setReady();
      case (readyMode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      start     = 1'b0;
      wr_strobe = 1'b0;
      setReady();
   endtask

   // Frame model: the dump window from the snapshot rule, each entry as
   // A5 plus its bytes MSB first, then 5A, count mod 256 and the flag.
   task automatic buildExpected(input bit wrapped, input int ptr, input int flag);
      int count;
      int base;
      int a;
      logic [31:0] e;
      expBytes.delete();
      expAddr.delete();
      count = wrapped ? DEPTH : ptr;
      base  = wrapped ? ptr : 0;
      for (int i = 0; i < count; i++) begin
         a = (base + i) % DEPTH;
         expAddr.push_back(a);
         e = ram[a];
         expBytes.push_back(SYNC_BYTE);
         expBytes.push_back(e[31:24]);
         expBytes.push_back(e[23:16]);
         expBytes.push_back(e[15:8]);
         expBytes.push_back(e[7:0]);
      end
      expBytes.push_back(TRAIL_BYTE);
      expBytes.push_back(8'(count % 256));
      expBytes.push_back(8'(flag));
   endtask

   task automatic applyStimulus(input vec_t v);
      int cyc;
      int n;
      int firstBad;
      int addrBad;
      buildExpected(v.wrapped, v.ptr, v.expFlag);
      gotBytes.delete();
      gotAddr.delete();
      doneCnt   = 0;
      stableErr = 0;
      readyMode = (v.stall > 0) ? 2 : v.rmode;
      setReady();
      wr_wrapped = v.wrapped;
      wr_ptr     = PB'(v.ptr);
      start      = 1'b1;
      wr_strobe  = v.strobeWithStart;
      tick();
      if (v.strobeWithStart) wr_ptr = wr_ptr + PB'(1);
      cyc = 0;
      while (doneCnt == 0 && cyc < BUDGET) begin
         if (cyc < v.strobes) wr_strobe = 1'b1;
         if (cyc == v.restartAt) begin
            start      = 1'b1;
            wr_ptr     = wr_ptr + PB'(7);
            wr_wrapped = ~wr_wrapped;
         end
         if (v.stall > 0 && cyc == v.stall) begin
            checkOutput({"stall_valid_", v.name}, 32'(tx_valid), 32'd1);
            checkOutput({"stall_hold_", v.name}, 32'(tx_data), 32'(expBytes[0]));
            readyMode = v.rmode;
            setReady();
         end
         tick();
         cyc++;
      end
      checkOutput({"timeout_", v.name}, 32'(doneCnt > 0), 32'd1);
      tick();
      tick();
      checkOutput({"len_", v.name}, 32'(gotBytes.size()), 32'(expBytes.size()));
      n = (gotBytes.size() < expBytes.size()) ? gotBytes.size() : expBytes.size();
      firstBad = -1;
      for (int i = 0; i < n; i++) begin
         if (gotBytes[i] !== expBytes[i]) begin
            firstBad = i;
            break;
         end
      end
      checks++;
      if (firstBad >= 0) begin
         errors++;
         $display("[TB] FAIL frame_%s: byte %0d got %02h expected %02h",
                  v.name, firstBad, gotBytes[firstBad], expBytes[firstBad]);
      end
      addrBad = (gotAddr.size() != expAddr.size()) ? 0 : -1;
      for (int i = 0; i < gotAddr.size() && i < expAddr.size(); i++) begin
         if (addrBad < 0 && gotAddr[i] != expAddr[i]) addrBad = i;
      end
      checks++;
      if (addrBad >= 0) begin
         errors++;
         $display("[TB] FAIL addr_%s: index %0d got %0d reads expected %0d reads",
                  v.name, addrBad, gotAddr.size(), expAddr.size());
      end
      checkOutput({"done_once_", v.name}, 32'(doneCnt), 32'd1);
      checkOutput({"overflow_", v.name}, 32'(overflow), 32'(v.expFlag));
      checkOutput({"stable_", v.name}, 32'(stableErr), 32'd0);
      checkOutput({"busy_idle_", v.name}, 32'(busy), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   task automatic fillRam();
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = pack_entry(16'($urandom), 3'($urandom), 5'($urandom), 5'($urandom));
      end
   endtask

   logic [7:0] lit43 [18];

   initial begin
      int cyc;
      vec_t v;
      rst_n      = 1'b0;
      start      = 1'b0;
      wr_ptr     = '0;
      wr_wrapped = 1'b0;
      wr_strobe  = 1'b0;
      tx_ready   = 1'b0;
      readyMode  = 0;
      doneCnt    = 0;
      stableErr  = 0;
      prevStall  = 1'b0;
      lit43 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h40, 8'hA5, 8'h55, 8'h66, 8'h77,
                8'h88, 8'hA5, 8'h99, 8'hAA, 8'hBB, 8'hC8, 8'h5A, 8'h03, 8'h00};
      fillRam();
      ram[0] = 32'h11223340;
      ram[1] = 32'h55667788;
      ram[2] = 32'h99AABBC8;

      repeat (3) tick();
      checkAllZero("reset");
      rst_n = 1'b1;
      tick();

      //             name        wrap ptr rmode stall strobes sws restart flag
      vecs.push_back(mk("empty",    0,   0,  0,    0,   0,     0,  -1,     0));
      vecs.push_back(mk("req43",    0,   3,  0,    0,   0,     0,  -1,     0));
      vecs.push_back(mk("wrap126",  1, 126,  0,    0,   0,     0,  -1,     0));
      vecs.push_back(mk("rndready", 0,   3,  1,    0,   0,     0,  -1,     0));
      vecs.push_back(mk("ovf",      1,   5,  0,    0,   3,     0,  -1,     1));
      vecs.push_back(mk("noovf",    1,   5,  0,    0,   0,     0,  -1,     0));
      vecs.push_back(mk("stall",    0,   2,  1,  200,   0,     0,  -1,     0));
      vecs.push_back(mk("busystart",0,   4,  0,    0,   0,     0,   6,     0));
      vecs.push_back(mk("samestrb", 1,  10,  0,    0,   0,     1,  -1,     0));
      vecs.push_back(mk("fewstrb",  0,  20,  0,    0,  50,     0,  -1,     0));
      vecs.push_back(mk("manystrb", 0, 100,  0,    0,  40,     0,  -1,     1));

      foreach (vecs[k]) begin
         applyStimulus(vecs[k]);
         if (vecs[k].name == "req43" || vecs[k].name == "rndready") begin
            checks++;
            if (gotBytes.size() != 18) begin
               errors++;
               $display("[TB] FAIL literal_%s: got %0d bytes expected 18",
                        vecs[k].name, gotBytes.size());
            end else begin
               for (int i = 0; i < 18; i++) begin
                  if (gotBytes[i] !== lit43[i]) begin
                     errors++;
                     $display("[TB] FAIL literal_%s: byte %0d got %02h expected %02h",
                              vecs[k].name, i, gotBytes[i], lit43[i]);
                     break;
                  end
               end
            end
         end
      end

      // Reset in the middle of the second data byte of a wrapped dump that
      // has already flagged overflow.
      gotBytes.delete();
      readyMode  = 0;
      setReady();
      wr_wrapped = 1'b1;
      wr_ptr     = '0;
      start      = 1'b1;
      tick();
      wr_strobe  = 1'b1;
      tick();
      cyc = 0;
      while (gotBytes.size() < 2 && cyc < 100) begin
         tick();
         cyc++;
      end
      checkOutput("midreset_reach", 32'(gotBytes.size() >= 2), 32'd1);
      checkOutput("midreset_pre_ovf", 32'(overflow), 32'd1);
      checkOutput("midreset_pre_byte", 32'(tx_data), 32'(ram[0][23:16]));
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      tick();
      rst_n = 1'b1;
      tick();
      applyStimulus(mk("afterreset", 0, 3, 0, 0, 0, 0, -1, 0));

      // Randomised dumps against the frame model; strobes stay within the
      // free-slot margin so no overflow is expected.
      for (int r = 0; r < 6; r++) begin
         fillRam();
         v = mk($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                $urandom_range(0, DEPTH - 1), 1, 0, 0, 0, -1, 0);
         if (!v.wrapped) v.strobes = $urandom_range(0, DEPTH - v.ptr);
         applyStimulus(v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
